// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI4 RAM slave:
//   - burst type encodings (BURST_FIXED / BURST_INCR / BURST_WRAP)
//   - response codes (RESP_OKAY / RESP_SLVERR)
//   - FSM state encoding (ST_IDLE .. ST_RDATA)
//   - burst legality helpers
// Optional feature macro: AXI_RAM_SLAVE_WRAP_EN (native WRAP burst support).
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WDATA = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RADDR = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    // A WRAP burst may only be 2, 4, 8 or 16 beats long (len = beats - 1).
    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Error flag a burst starts with, decided purely by its type and length.
    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
`ifdef AXI_RAM_SLAVE_WRAP_EN
        return (burst == BURST_WRAP) && !wrap_len_ok(len);
`else
        // WRAP is not supported natively: it runs as INCR but is flagged.
        return (burst == BURST_WRAP);
`endif
    endfunction

endpackage

// File: rtl/ram_sp_be.sv
// -----------------------------------------------------------------------------
// ram_sp_be
// Single-port RAM, 2^ADDR_WIDTH x 32 bits, with 4 byte-write enables and a
// registered read port (1-cycle latency). The read register only loads on a
// pure read (en_i with no byte enables), so it holds its value across writes
// and idle cycles. The array itself is not reset; only the read register is.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (read register only)
//   en_i     access enable
//   we_i     byte write enables (all zero = read)
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module ram_sp_be #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    // Byte-lane writes into the storage array.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read data, loaded only on read accesses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 32'h0000_0000;
        end else if (en_i && (we_i == 4'b0000)) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// -----------------------------------------------------------------------------
// axi_ram_slave
// AXI4 slave backed by a single-ported, byte-writable on-chip RAM. One
// transaction at a time; simultaneous AW/AR requests alternate fairly using a
// last-served flag (write wins first after reset).
// Ports: CLK, RST (async active-high), AXI4 AW/W/B/AR/R channels with 1-bit IDs,
//        32-bit data. RAM index = S_AXI_xxADDR[ADDR_WIDTH+1:2].
// Optional feature macro: AXI_RAM_SLAVE_WRAP_EN
//   defined   : WRAP bursts wrap inside an aligned (len+1)-word window, OKAY.
//               Illegal WRAP lengths answer SLVERR and run as INCR.
//   undefined : WRAP runs as INCR and every response of the burst is SLVERR.
// -----------------------------------------------------------------------------
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int AW = ADDR_WIDTH;

    // Next word index for a beat; arithmetic wraps modulo 2^AW by width.
    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx,
                                               input logic [1:0]    burst,
                                               input logic [7:0]    len);
        logic [AW-1:0] inc;
        logic [AW-1:0] res;
        inc = idx + AW'(1);
        case (burst)
            BURST_FIXED: res = idx;
            BURST_INCR:  res = inc;
`ifdef AXI_RAM_SLAVE_WRAP_EN
            // Legal lengths are 2^k-1, so len itself is the in-window mask.
            BURST_WRAP:  res = wrap_len_ok(len) ? ((idx & ~AW'(len)) | (inc & AW'(len))) : inc;
`else
            BURST_WRAP:  res = inc;
`endif
            default:     res = inc;
        endcase
        return res;
    endfunction

    logic [2:0]    state_q,  state_d;
    logic          last_wr_q, last_wr_d;
    logic [AW-1:0] idx_q,    idx_d;
    logic [7:0]    len_q,    len_d;
    logic [7:0]    beat_q,   beat_d;
    logic [1:0]    burst_q,  burst_d;
    logic          err_q,    err_d;
    logic          bid_q,    bid_d;
    logic          rid_q,    rid_d;
    logic [1:0]    bresp_q,  bresp_d;
    logic [1:0]    rresp_q,  rresp_d;
    logic          bvalid_q, bvalid_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q,  rlast_d;

    logic          aw_win_s, ar_win_s;
    logic          aw_hs_s, ar_hs_s, w_hs_s;
    logic          wlast_bad_s;
    logic          ram_en_s;
    logic [3:0]    ram_we_s;
    logic [31:0]   ram_rdata_s;
    logic          unused_s;

    // When both channels request, the one not served last goes first.
    assign aw_win_s = S_AXI_AWVALID && (!S_AXI_ARVALID || !last_wr_q);
    assign ar_win_s = S_AXI_ARVALID && (!S_AXI_AWVALID ||  last_wr_q);

    // Readies are gated by RST so they read 0 while reset is held.
    assign S_AXI_AWREADY = !RST && (state_q == ST_IDLE)  && aw_win_s;
    assign S_AXI_ARREADY = !RST && (state_q == ST_IDLE)  && ar_win_s;
    assign S_AXI_WREADY  = !RST && (state_q == ST_WDATA);

    assign aw_hs_s = S_AXI_AWVALID && S_AXI_AWREADY;
    assign ar_hs_s = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_hs_s  = S_AXI_WVALID  && S_AXI_WREADY;

    // WLAST must appear exactly on the final counted beat.
    assign wlast_bad_s = (beat_q == len_q) ? !S_AXI_WLAST : S_AXI_WLAST;

    // Single port: writes happen on W beats, reads are issued in RADDR.
    assign ram_en_s = w_hs_s || (state_q == ST_RADDR);
    assign ram_we_s = w_hs_s ? S_AXI_WSTRB : 4'b0000;

    ram_sp_be #(.ADDR_WIDTH(AW)) u_ram (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (ram_en_s),
        .we_i    (ram_we_s),
        .addr_i  (idx_q),
        .wdata_i (S_AXI_WDATA),
        .rdata_o (ram_rdata_s)
    );

    // Upper and byte-offset address bits do not select RAM words.
    assign unused_s = ^{S_AXI_AWADDR[31:AW+2], S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[31:AW+2], S_AXI_ARADDR[1:0]};

    // Transaction FSM next-state and output-register next values.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        idx_d     = idx_q;
        len_d     = len_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        err_d     = err_q;
        bid_d     = bid_q;
        rid_d     = rid_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    state_d   = ST_WDATA;
                    last_wr_d = 1'b1;
                    bid_d     = S_AXI_AWID;
                    idx_d     = S_AXI_AWADDR[AW+1:2];
                    len_d     = S_AXI_AWLEN;
                    burst_d   = S_AXI_AWBURST;
                    beat_d    = 8'd0;
                    err_d     = burst_err(S_AXI_AWBURST, S_AXI_AWLEN);
                end else if (ar_hs_s) begin
                    state_d   = ST_RADDR;
                    last_wr_d = 1'b0;
                    rid_d     = S_AXI_ARID;
                    idx_d     = S_AXI_ARADDR[AW+1:2];
                    len_d     = S_AXI_ARLEN;
                    burst_d   = S_AXI_ARBURST;
                    beat_d    = 8'd0;
                    err_d     = burst_err(S_AXI_ARBURST, S_AXI_ARLEN);
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (w_hs_s) begin
                    idx_d = next_idx(idx_q, burst_q, len_q);
                    err_d = err_q | wlast_bad_s;
                    // The burst ends on the counter regardless of WLAST.
                    if (beat_q == len_q) begin
                        state_d  = ST_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q | wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        beat_d   = beat_q + 8'd1;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WRESP: begin
                if (S_AXI_BREADY) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    state_d  = ST_WRESP;
                end
            end
            ST_RADDR: begin
                state_d  = ST_RDATA;
                rvalid_d = 1'b1;
                rlast_d  = (beat_q == len_q);
                rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            ST_RDATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RADDR;
                        idx_d   = next_idx(idx_q, burst_q, len_q);
                        beat_d  = beat_q + 8'd1;
                    end
                end else begin
                    state_d = ST_RDATA;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bvalid_d = 1'b0;
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            last_wr_q <= 1'b0;
            idx_q     <= '0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
            bid_q     <= 1'b0;
            rid_q     <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            bid_q     <= bid_d;
            rid_q     <= rid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    assign S_AXI_BID    = bid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_RID    = rid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RLAST  = rlast_q;
    // RAM read register only reloads in RADDR, so data is stable in RDATA.
    assign S_AXI_RDATA  = ram_rdata_s;

endmodule

// File: tb/tb_axi_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_ram_slave
// Directed self-checking bench for axi_ram_slave. Expected values are written
// by hand from the intended behaviour of the slave. Honours the
// AXI_RAM_SLAVE_WRAP_EN macro for the WRAP read expectations.
// -----------------------------------------------------------------------------
module tb_axi_ram_slave;

    logic        CLK;
    logic        RST;
    logic        S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic        S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic        S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] wdata_v [0:15];
    logic [31:0] rd_data [0:15];
    logic [1:0]  rd_resp [0:15];
    logic        rd_last [0:15];
    logic        rd_id;
    logic [1:0]  b_resp;
    logic        b_id;
    logic [31:0] held;

    axi_ram_slave dut (
        .CLK           (CLK),
        .RST           (RST),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present AW and hold it until accepted; caller is off the clock edge.
    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic id);
        int n;
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWBURST = burst; S_AXI_AWID = id;
        n = 0;
        #1;
        while (!S_AXI_AWREADY && n < 100) begin @(negedge CLK); #1; n++; end
        chk("aw_accept", {31'd0, S_AXI_AWREADY}, 32'd1);
        @(posedge CLK); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic id);
        int n;
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARBURST = burst; S_AXI_ARID = id;
        n = 0;
        #1;
        while (!S_AXI_ARREADY && n < 100) begin @(negedge CLK); #1; n++; end
        chk("ar_accept", {31'd0, S_AXI_ARREADY}, 32'd1);
        @(posedge CLK); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    // W beats back to back; early >= 0 puts WLAST on that beat only.
    task automatic send_w(input logic [7:0] len, input logic [3:0] strb, input int early);
        int n;
        for (int b = 0; b <= int'(len); b++) begin
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = wdata_v[b]; S_AXI_WSTRB = strb;
            S_AXI_WLAST  = (early >= 0) ? (b == early) : (b == int'(len));
            n = 0;
            #1;
            while (!S_AXI_WREADY && n < 100) begin @(negedge CLK); #1; n++; end
            chk("w_beat_wait", n, 0);
            @(posedge CLK); #1;
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    endtask

    task automatic get_b();
        int n;
        S_AXI_BREADY = 1'b1;
        n = 0;
        #1;
        while (!S_AXI_BVALID && n < 100) begin @(negedge CLK); #1; n++; end
        chk("b_latency", n, 0);
        chk("b_wready_low", {31'd0, S_AXI_WREADY}, 32'd0);
        b_resp = S_AXI_BRESP; b_id = S_AXI_BID;
        @(posedge CLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    // Collect len+1 beats with RREADY high; each beat should arrive 2 cycles apart.
    task automatic get_r(input logic [7:0] len);
        int n;
        S_AXI_RREADY = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            #1;
            while (!S_AXI_RVALID && n < 100) begin @(negedge CLK); #1; n++; end
            chk("r_beat_wait", n, 2);
            rd_data[b] = S_AXI_RDATA; rd_resp[b] = S_AXI_RRESP;
            rd_last[b] = S_AXI_RLAST; rd_id = S_AXI_RID;
            @(posedge CLK); #1;
        end
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        int n;
        RST = 1'b1;
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h0; S_AXI_AWLEN = 8'd0; S_AXI_AWBURST = 2'b01;
        S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WLAST = 1'b0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h0;
        S_AXI_ARLEN = 8'd0; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        // Reset state
        chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        chk("rst_wready",  {31'd0, S_AXI_WREADY},  32'd0);
        chk("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
        chk("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
        chk("rst_rlast",   {31'd0, S_AXI_RLAST},   32'd0);
        chk("rst_bid",     {31'd0, S_AXI_BID},     32'd0);
        chk("rst_rid",     {31'd0, S_AXI_RID},     32'd0);
        chk("rst_bresp",   {30'd0, S_AXI_BRESP},   32'd0);
        chk("rst_rresp",   {30'd0, S_AXI_RRESP},   32'd0);
        chk("rst_rdata",   S_AXI_RDATA,            32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // INCR write 0x100 x4, then read it back
        for (int i = 0; i < 4; i++) wdata_v[i] = 32'hA0 + 32'(i);
        send_aw(32'h100, 8'd3, 2'b01, 1'b1);
        send_w(8'd3, 4'hF, -1);
        get_b();
        chk("incr_bresp", {30'd0, b_resp}, 32'd0);
        chk("incr_bid",   {31'd0, b_id},   32'd1);
        send_ar(32'h100, 8'd3, 2'b01, 1'b1);
        get_r(8'd3);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rd_data[i], 32'hA0 + 32'(i));
            chk("incr_rresp", {30'd0, rd_resp[i]}, 32'd0);
            chk("incr_rlast", {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("incr_rid", {31'd0, rd_id}, 32'd1);

        // Byte strobes: 0xDEADBEEF with WSTRB=0101 over zero
        wdata_v[0] = 32'h0;
        send_aw(32'h40, 8'd0, 2'b01, 1'b0);
        send_w(8'd0, 4'hF, -1);
        get_b();
        wdata_v[0] = 32'hDEADBEEF;
        send_aw(32'h40, 8'd0, 2'b01, 1'b0);
        send_w(8'd0, 4'b0101, -1);
        get_b();
        chk("strb_bresp", {30'd0, b_resp}, 32'd0);
        send_ar(32'h40, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("strb_rdata", rd_data[0], 32'h00AD00EF);

        // Arbitration with AWVALID and ARVALID both high: write, read, write
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h200; S_AXI_AWLEN = 8'd0; S_AXI_AWBURST = 2'b01;
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h200; S_AXI_ARLEN = 8'd0; S_AXI_ARBURST = 2'b01;
        #1;
        chk("arb1_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        chk("arb1_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        wdata_v[0] = 32'h11111111;
        send_aw(32'h200, 8'd0, 2'b01, 1'b0);
        send_w(8'd0, 4'hF, -1);
        get_b();
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h204;
        #1;
        chk("arb2_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        chk("arb2_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        send_ar(32'h200, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("arb2_rdata", rd_data[0], 32'h11111111);
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h204;
        #1;
        chk("arb3_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        chk("arb3_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        wdata_v[0] = 32'h22222222;
        send_aw(32'h204, 8'd0, 2'b01, 1'b0);
        send_w(8'd0, 4'hF, -1);
        get_b();
        send_ar(32'h204, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("arb3_rdata", rd_data[0], 32'h22222222);

        // Early WLAST: two beats still accepted, SLVERR
        wdata_v[0] = 32'h55; wdata_v[1] = 32'h66;
        send_aw(32'h300, 8'd1, 2'b01, 1'b0);
        send_w(8'd1, 4'hF, 0);
        get_b();
        chk("wlast_bresp", {30'd0, b_resp}, 32'd2);
        send_ar(32'h304, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("wlast_beat1", rd_data[0], 32'h66);

        // FIXED burst: all beats land on one word, last one stays
        wdata_v[0] = 32'h1; wdata_v[1] = 32'h2; wdata_v[2] = 32'h3;
        send_aw(32'h310, 8'd2, 2'b00, 1'b0);
        send_w(8'd2, 4'hF, -1);
        get_b();
        chk("fixed_bresp", {30'd0, b_resp}, 32'd0);
        send_ar(32'h310, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("fixed_rdata", rd_data[0], 32'h3);

        // Top of RAM wraps to word 0
        wdata_v[0] = 32'hE0; wdata_v[1] = 32'hE1;
        send_aw(32'h3FFC, 8'd1, 2'b01, 1'b0);
        send_w(8'd1, 4'hF, -1);
        get_b();
        send_ar(32'h0, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("top_wrap_w0", rd_data[0], 32'hE1);
        send_ar(32'h3FFC, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("top_wrap_top", rd_data[0], 32'hE0);

        // WRAP read at 0x18, 4 beats, over words 4..9 = 0xC4..0xC9
        for (int i = 0; i < 6; i++) wdata_v[i] = 32'hC4 + 32'(i);
        send_aw(32'h10, 8'd5, 2'b01, 1'b0);
        send_w(8'd5, 4'hF, -1);
        get_b();
        send_ar(32'h18, 8'd3, 2'b10, 1'b0);
        get_r(8'd3);
`ifdef AXI_RAM_SLAVE_WRAP_EN
        chk("wrap_d0", rd_data[0], 32'hC6);
        chk("wrap_d1", rd_data[1], 32'hC7);
        chk("wrap_d2", rd_data[2], 32'hC4);
        chk("wrap_d3", rd_data[3], 32'hC5);
        for (int i = 0; i < 4; i++) chk("wrap_rresp", {30'd0, rd_resp[i]}, 32'd0);
`else
        chk("wrap_d0", rd_data[0], 32'hC6);
        chk("wrap_d1", rd_data[1], 32'hC7);
        chk("wrap_d2", rd_data[2], 32'hC8);
        chk("wrap_d3", rd_data[3], 32'hC9);
        for (int i = 0; i < 4; i++) chk("wrap_rresp", {30'd0, rd_resp[i]}, 32'd2);
`endif
        chk("wrap_rlast", {31'd0, rd_last[3]}, 32'd1);

        // Stall beat 0 for 5 cycles, then reset during beat 1
        send_ar(32'h100, 8'd3, 2'b01, 1'b0);
        n = 0;
        #1;
        while (!S_AXI_RVALID && n < 100) begin @(negedge CLK); #1; n++; end
        chk("stall_first", S_AXI_RDATA, 32'hA0);
        held = S_AXI_RDATA;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK); #1;
            chk("stall_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
            chk("stall_rdata",  S_AXI_RDATA, held);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge CLK); #1;
        S_AXI_RREADY = 1'b0;
        n = 0;
        #1;
        while (!S_AXI_RVALID && n < 100) begin @(negedge CLK); #1; n++; end
        chk("stall_beat1", S_AXI_RDATA, 32'hA1);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("midrst_rdata",  S_AXI_RDATA, 32'h0);
        chk("midrst_rlast",  {31'd0, S_AXI_RLAST}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        send_ar(32'h104, 8'd0, 2'b01, 1'b0);
        get_r(8'd0);
        chk("post_rst_read", rd_data[0], 32'hA1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4 slave that backs the cores' AXI master port with an on-chip, single-ported, byte-writable RAM. It is the responder end of the bus the MMU/cache masters drive. Simulation and FPGA builds attach it directly to the master's M_AXI_* signals to serve instruction and data cache line fills and write-throughs.

## Interface
- ADDR_WIDTH, 12, log2 of RAM depth in 32-bit words; RAM index = S_AXI_xxADDR[ADDR_WIDTH+1:2], upper address bits ignored
- CLK  input  1  sole clock
- RST  input  1  asynchronous, active-high reset
- S_AXI_AWID  input  1  write ID, echoed on S_AXI_BID
- S_AXI_AWADDR  input  32  burst start byte address
- S_AXI_AWLEN  input  8  beats minus one
- S_AXI_AWBURST  input  2  00 FIXED, 01 INCR, 10 WRAP
- S_AXI_AWVALID / S_AXI_AWREADY  input / output  1  AW handshake
- S_AXI_WDATA  input  32  write data
- S_AXI_WSTRB  input  4  byte enables
- S_AXI_WLAST  input  1  last write beat from master
- S_AXI_WVALID / S_AXI_WREADY  input / output  1  W handshake
- S_AXI_BID  output  1  registered AWID
- S_AXI_BRESP  output  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID / S_AXI_BREADY  output / input  1  B handshake
- S_AXI_ARID  input  1  read ID, echoed on S_AXI_RID
- S_AXI_ARADDR  input  32  burst start byte address
- S_AXI_ARLEN  input  8  beats minus one
- S_AXI_ARBURST  input  2  as AWBURST
- S_AXI_ARVALID / S_AXI_ARREADY  input / output  1  AR handshake
- S_AXI_RID  output  1  registered ARID
- S_AXI_RDATA  output  32  read data
- S_AXI_RRESP  output  2  per-beat response
- S_AXI_RLAST  output  1  high on the final beat
- S_AXI_RVALID / S_AXI_RREADY  output / input  1  R handshake
## Operation
- FSM states: IDLE, WDATA, WRESP, RADDR, RDATA. One transaction at a time, no outstanding queue. The RAM is single-ported.
- IDLE arbitration: if only one of AWVALID/ARVALID is high, that channel wins. If both are high, the channel *not* served last wins (1-bit last_wr flag, reset 0). The winner's READY is high combinationally in IDLE; the loser's READY stays 0.
- On AW handshake: latch ID, addr, len, burst; clear beat counter and err flag; go to WDATA.
- WDATA: WREADY=1. Each W handshake writes the WSTRB-enabled bytes at the current word and advances the address. After beat len+1, go to WRESP.
- WLAST mismatch: WLAST on an earlier beat, or missing on beat len+1, sets err. The burst still ends on the counter.
- WRESP: BVALID=1, BRESP = err ? 10 : 00. Return to IDLE on BREADY.
- On AR handshake: latch fields and go to RADDR. RADDR issues the RAM read, then goes to RDATA.
- RDATA: RVALID=1, RDATA held, RLAST = (beat==len). On RREADY, advance the address; go to RADDR if not last, else IDLE.
- Address arithmetic is on the word index, modulo 2^ADDR_WIDTH, so the top of RAM wraps silently to 0.
  - FIXED: the index is held for the whole burst.
  - INCR: +1 per beat.
  - WRAP: see Configuration.
## Timing
- Reset values: AWREADY, ARREADY, WREADY, BVALID, RVALID and RLAST are 0; BID, RID, BRESP, RRESP are 0; RDATA is 32'h0; last_wr is 0; FSM is in IDLE. RAM contents are not reset.
- Write burst of N beats: AW handshake at cycle t gives WREADY from t+1. With WVALID held high, the last beat is at t+N, BVALID at t+N+1.
- Read: AR handshake at cycle t gives the first RVALID at t+2. With RREADY held high, throughput is one beat per 2 cycles.
- BVALID/RVALID and all R payload stay stable until their handshake. WREADY is never asserted outside WDATA.
- Simultaneous AWVALID+ARVALID from reset: the write is served first.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously). Any partially written burst keeps the beats already written.
## Configuration
- AXI_RAM_SLAVE_WRAP_EN defined: WRAP bursts wrap within an aligned window of (len+1) words and return OKAY. Legal WRAP lengths are 2, 4, 8 and 16 beats; any other len sets err.
- AXI_RAM_SLAVE_WRAP_EN undefined: WRAP is executed as INCR, and every R beat or the B response of that burst returns SLVERR (10).
## Structure
- Shared package axi_pkg: burst encodings (BURST_FIXED/INCR/WRAP), response codes (RESP_OKAY/RESP_SLVERR), and the FSM state encoding.
- One sub-module ram_sp_be: single-port RAM with 2^ADDR_WIDTH x 32 entries, 4 byte-write enables and registered read data (1-cycle latency).
## Test plan
- INCR write, AWADDR=0x100, AWLEN=3, data 0xA0..0xA3, WSTRB=F, then INCR read of the same range -> BRESP=00; reads return 0xA0..0xA3 with RLAST on beat 3; RRESP=00.
- Single write of 0xDEADBEEF with WSTRB=0101 over 0x00000000 at addr 0x40, then read -> 0x00AD00EF.
- AWVALID and ARVALID both high for 3 consecutive transactions -> order is write, read, write; no deadlock.
- AWLEN=1 with WLAST asserted on beat 0 -> 2 beats accepted, BRESP=10.
- WRAP read, ARADDR=0x18, ARLEN=3 -> with macro: word indices 6,7,4,5 and RRESP=00; without macro: indices 6,7,8,9 and RRESP=10.
- RREADY held low for 5 cycles on beat 0, then RST pulsed during beat 1 -> RDATA stable while stalled; after RST, RVALID=0 and FSM in IDLE.
